// File: rtl/ring_clk_downsampler.sv
// Programmable clock divider behind the ring oscillator: registered 50% duty clk_o,
// per-period tick, and a valid/ready config port applied only on period boundaries.
module ring_clk_downsampler #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic               ds_v_i,
    input  logic [width_p-1:0] ds_val_i,
    output logic               ds_ready_o,
    output logic               clk_o,
    output logic               tick_o,
    output logic [width_p-1:0] ds_active_o
);

    typedef enum logic [1:0] {
        STOP,
        RUN_LO,
        RUN_HI
    } mode_e;

    logic [width_p-1:0] ds_r;
    logic [width_p-1:0] cnt_r;
    logic [width_p-1:0] pend_val_r;
    logic               clk_r;
    logic               pend_r;
    logic               tick_r;

    mode_e mode;
    logic  term;
    logic  accept;

    // The running state is the enable input paired with the output flop.
    always_comb begin
        // NOTE: default first so every path assigns mode and no latch is inferred.
        mode = STOP;
        if (en_i) begin
            mode = clk_r ? RUN_HI : RUN_LO;
        end
    end

    // >= rather than == keeps the divider sane if cnt_r ever exceeds a newly applied N.
    assign term   = (cnt_r >= ds_r);
    assign accept = ds_v_i & ~pend_r;

    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous and sampled only on the oscillator edge; it also drops any pending config.
        if (reset_i) begin
            ds_r       <= '0;
            cnt_r      <= '0;
            clk_r      <= 1'b0;
            pend_r     <= 1'b0;
            pend_val_r <= '0;
            tick_r     <= 1'b0;
        end else begin
            // Accept needs pend_r=0 and apply needs pend_r=1, so they never collide.
            if (accept) begin
                pend_r     <= 1'b1;
                pend_val_r <= ds_val_i;
            end

            unique case (mode)
                STOP: begin
                    cnt_r  <= '0;
                    clk_r  <= 1'b0;
                    tick_r <= 1'b0;
                    if (pend_r) begin
                        ds_r   <= pend_val_r;
                        pend_r <= 1'b0;
                    end
                end
                RUN_LO: begin
                    if (term) begin
                        clk_r  <= 1'b1;
                        cnt_r  <= '0;
                        tick_r <= 1'b1;
                    end else begin
                        cnt_r  <= cnt_r + 1'b1;
                        tick_r <= 1'b0;
                    end
                end
                RUN_HI: begin
                    tick_r <= 1'b0;
                    if (term) begin
                        clk_r <= 1'b0;
                        cnt_r <= '0;
                        // New ratio lands on the falling edge so the next low phase uses it.
                        if (pend_r) begin
                            ds_r   <= pend_val_r;
                            pend_r <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: begin
                    cnt_r  <= '0;
                    clk_r  <= 1'b0;
                    tick_r <= 1'b0;
                end
            endcase
        end
    end

    assign ds_ready_o  = ~pend_r;
    assign clk_o       = clk_r;
    assign tick_o      = tick_r;
    assign ds_active_o = ds_r;

endmodule
